serial_adder_ctrl: RTL and testbench
====================================

Name: serial_adder_ctrl

Overview:
- Bit-serial adder controller that feeds one existing full_adder instance one operand bit pair per clock, LSB first.
- Registers the carry between cycles and assembles the WIDTH-bit sum in a shift register.
- Sits directly upstream of and around the full_adder cell.
- Trades area for latency in the arithmetic datapath; valid/ready handshakes on both sides.

Parameters:
- WIDTH, 8, operand and sum width in bits (>=2)
- CNT_W, 4, bit-counter width; must satisfy 2**CNT_W >= WIDTH

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operands present
- in_ready  output  1  block can accept operands
- in_a  input  WIDTH  operand A
- in_b  input  WIDTH  operand B
- out_valid  output  1  result present
- out_ready  input  1  consumer takes result
- out_sum  output  WIDTH  sum bits
- out_carry  output  1  carry out of MSB

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_sum=0, out_carry=0. Internal a_sh, b_sh, sum_sh, carry and cnt are all 0.
- Full adder instance: exactly one full_adder. Its input cout is the carry-in, driven by the carry register. Its output cin is the carry-out. Inputs a and b are driven by a_sh[0] and b_sh[0].
- State IDLE:
  - in_ready=1.
  - On in_valid & in_ready: a_sh<=in_a, b_sh<=in_b, carry<=0, cnt<=0, state<=RUN.
- State RUN:
  - in_ready=0.
  - Each edge: sum_sh<={fa_sum, sum_sh[WIDTH-1:1]}, a_sh<=a_sh>>1, b_sh<=b_sh>>1, carry<=fa_carry_out, cnt<=cnt+1.
  - When cnt==WIDTH-1 on that edge: state<=DONE.
- State DONE:
  - out_valid=1. out_sum=sum_sh, out_carry=carry; both stable while out_valid=1.
  - in_ready=0.
  - On out_ready: state<=IDLE, out_valid drops next cycle.
- Latency: out_valid rises exactly WIDTH+1 edges after the accept edge. That is WIDTH RUN edges plus the DONE transition, i.e. the result is visible in the cycle after the WIDTH-th RUN edge.
- Throughput: at most one operation per WIDTH+2 cycles with out_ready held high. No overlap between operations.
- Arithmetic: unsigned, modulo 2**WIDTH. out_carry is bit WIDTH of the true sum.
- Boundary rules:
  - in_valid while not IDLE: ignored and not captured; the producer must hold it.
  - out_ready while not DONE: ignored.
  - DONE held indefinitely if out_ready=0; the result must not change.
  - rst during RUN or DONE: immediate return to reset values on that edge; partial result discarded, no out_valid pulse.
  - in_valid and rst together: rst wins, nothing captured.

Optional Feature:
- Macro: SERIAL_SUB_EN.
- Defined:
  - Adds input port sub (1 bit), sampled at accept.
  - sub=1: b_sh loaded with ~in_b and carry initialised to 1, so the result is in_a-in_b modulo 2**WIDTH.
  - out_carry=1 means no borrow (in_a>=in_b).
  - sub=0: identical to plain add.
- Undefined: no sub port; carry always initialised to 0; add only.

Test Plan:
- Reset then idle: after rst=1 for 2 cycles, in_ready=1, out_valid=0, out_sum=0x00, out_carry=0.
- Basic add (WIDTH=8): in_a=0x35, in_b=0x4A accepted -> out_valid after 9 edges, out_sum=0x7F, out_carry=0.
- Full carry ripple: in_a=0xFF, in_b=0x01 -> out_sum=0x00, out_carry=1. Also 0xFF+0xFF -> out_sum=0xFE, out_carry=1.
- Backpressure and ignored input: hold out_ready=0 for 5 cycles in DONE while pulsing in_valid with new operands -> result 0x7F/0 unchanged, in_ready=0, new operands not captured. Release out_ready -> IDLE next cycle, then accept the new operands.
- Reset mid-operation: assert rst at the 4th RUN edge of 0xFF+0x01 -> next cycle in_ready=1, out_valid=0, outputs 0. A following 0x10+0x20 yields 0x30/0.
- SERIAL_SUB_EN defined:
  - sub=1, 0x50-0x20 -> out_sum=0x30, out_carry=1.
  - sub=1, 0x20-0x50 -> out_sum=0xD0, out_carry=0.

Source files
------------

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl - bit-serial adder controller
//
// Adds two WIDTH-bit unsigned operands one bit per clock, LSB first, through a
// single full_adder cell. The carry is held in a register between bit steps.
// The sum bits are collected in a shift register and presented on the output
// handshake.
//
// Optional build macro: SERIAL_SUB_EN
//   When this macro is defined, the block gains a 'sub' input that is sampled
//   at accept. With sub=1 it loads ~in_b and a carry-in of 1, so the result is
//   in_a - in_b modulo 2**WIDTH, and out_carry=1 means no borrow.
//   When the macro is undefined, the block only adds.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   operands present (producer holds until accepted)
//   in_ready   block can accept operands (only in IDLE)
//   in_a/in_b  WIDTH-bit operands
//   sub        (SERIAL_SUB_EN only) subtract select, sampled at accept
//   out_valid  result present
//   out_ready  consumer takes result
//   out_sum    WIDTH-bit sum, stable while out_valid=1
//   out_carry  carry out of the MSB (for subtract: 1 = no borrow)

// One-bit full adder cell. The carry-in port is named cout and the carry-out
// port is named cin; this matches the port naming of the existing cell.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cout,
  output logic sum,
  output logic cin
);
  assign sum = a ^ b ^ cout;
  assign cin = (a & b) | (cout & (a ^ b));
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
`ifdef SERIAL_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_carry
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic             carry;
  logic [CNT_W-1:0] cnt;

  logic fa_sum;
  logic fa_carry_out;

  // Operand selection and carry-in seed at accept. Subtraction uses the
  // identity a - b = a + ~b + 1.
  logic [WIDTH-1:0] b_load;
  logic             carry_load;
`ifdef SERIAL_SUB_EN
  assign b_load     = sub ? ~in_b : in_b;
  assign carry_load = sub;
`else
  assign b_load     = in_b;
  assign carry_load = 1'b0;
`endif

  full_adder u_fa (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cout (carry),
    .sum  (fa_sum),
    .cin  (fa_carry_out)
  );

  // Control FSM and datapath registers. All outputs are registered.
  // Entering DONE takes one extra edge: the first DONE edge copies sum_sh
  // and carry into the output registers and raises out_valid. The result
  // appears WIDTH+1 edges after accept. out_ready is acted on only after
  // out_valid is visible, so the consumer can never skip a result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      a_sh      <= '0;
      b_sh      <= '0;
      sum_sh    <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_carry <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_sh     <= in_a;
            b_sh     <= b_load;
            carry    <= carry_load;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          // The new sum bit enters at the MSB. After WIDTH shifts, bit 0
          // of the sum has reached sum_sh[0].
          sum_sh <= {fa_sum, sum_sh[WIDTH-1:1]};
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          carry  <= fa_carry_out;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST_BIT) begin
            state <= DONE;
          end
        end
        DONE: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
            out_sum   <= sum_sh;
            out_carry <= carry;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl - self-checking bench for serial_adder_ctrl (WIDTH=8)
//
// A transaction-level model predicts the handshake flags and the result from
// plain arithmetic and a cycle timer. A compare process checks the DUT against
// this model on every falling edge. Directed tests also check hand-computed
// literal results and the accept-to-valid latency.
// Define SERIAL_SUB_EN to build and run the subtract cases.

module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_carry;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(W), .CNT_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
`ifdef SERIAL_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_carry (out_carry)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Transaction-level model. It accepts operands when idle, produces the
  // arithmetic result W+1 edges later, and holds that result until the
  // consumer takes it.
  logic         m_ready = 1'b1;
  logic         m_valid = 1'b0;
  logic [W-1:0] m_sum = '0;
  logic         m_carry = 1'b0;
  logic         m_busy = 1'b0;
  int           m_cnt = 0;
  logic [W:0]   m_total = '0;
  bit           chk_en = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_ready = 1'b1;
      m_valid = 1'b0;
      m_sum   = '0;
      m_carry = 1'b0;
      m_busy  = 1'b0;
      m_cnt   = 0;
    end else if (m_ready) begin
      if (in_valid) begin
        m_ready = 1'b0;
        m_busy  = 1'b1;
        m_cnt   = 0;
`ifdef SERIAL_SUB_EN
        if (sub)
          m_total = {1'b0, in_a} + {1'b0, ~in_b} + 9'd1;
        else
          m_total = {1'b0, in_a} + {1'b0, in_b};
`else
        m_total = {1'b0, in_a} + {1'b0, in_b};
`endif
      end
    end else if (m_busy) begin
      m_cnt++;
      if (m_cnt == W + 1) begin
        m_busy = 1'b0;
        m_valid = 1'b1;
        {m_carry, m_sum} = m_total;
      end
    end else if (m_valid && out_ready) begin
      m_valid = 1'b0;
      m_ready = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      checkOutput("cyc in_ready", in_ready, m_ready);
      checkOutput("cyc out_valid", out_valid, m_valid);
      checkOutput("cyc out_sum", out_sum, m_sum);
      checkOutput("cyc out_carry", out_carry, m_carry);
    end
  end

  // Wait (bounded) for out_valid. The wait starts at the falling edge right
  // after the accept edge; lat counts the falling edges until valid.
  task automatic waitResult(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  // Present operands for one cycle (block must be idle), then drop in_valid.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    @(negedge clk);
    in_a = a;
    in_b = b;
    sub = s;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic runOp(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic s, input logic [W-1:0] es, input logic ec);
    int lat;
    applyStimulus(a, b, s);
    waitResult(lat);
    checkOutput({name, " latency"}, lat, W + 1);
    checkOutput({name, " valid"}, out_valid, 1'b1);
    checkOutput({name, " sum"}, out_sum, es);
    checkOutput({name, " carry"}, out_carry, ec);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput({name, " release ready"}, in_ready, 1'b1);
    checkOutput({name, " release valid"}, out_valid, 1'b0);
  endtask

  initial begin
    int lat;
    rst = 1'b1;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    sub = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("reset in_ready", in_ready, 1'b1);
    checkOutput("reset out_valid", out_valid, 1'b0);
    checkOutput("reset out_sum", out_sum, 8'h00);
    checkOutput("reset out_carry", out_carry, 1'b0);

    runOp("add 35+4A", 8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0);
    runOp("add FF+01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    runOp("add FF+FF", 8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1);

    // Backpressure: hold the result while new operands are offered.
    applyStimulus(8'h35, 8'h4A, 1'b0);
    waitResult(lat);
    checkOutput("bp latency", lat, W + 1);
    in_a = 8'h01;
    in_b = 8'h02;
    for (int i = 0; i < 5; i++) begin
      in_valid = (i % 2 == 0);
      @(negedge clk);
      checkOutput("bp hold sum", out_sum, 8'h7F);
      checkOutput("bp hold carry", out_carry, 1'b0);
      checkOutput("bp hold valid", out_valid, 1'b1);
      checkOutput("bp in_ready", in_ready, 1'b0);
    end
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput("bp idle ready", in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    waitResult(lat);
    checkOutput("bp new latency", lat, W + 1);
    checkOutput("bp new sum", out_sum, 8'h03);
    checkOutput("bp new carry", out_carry, 1'b0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Reset at the 4th RUN edge discards the partial result.
    applyStimulus(8'hFF, 8'h01, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    checkOutput("midrst in_ready", in_ready, 1'b1);
    checkOutput("midrst out_valid", out_valid, 1'b0);
    checkOutput("midrst out_sum", out_sum, 8'h00);
    checkOutput("midrst out_carry", out_carry, 1'b0);
    runOp("add 10+20", 8'h10, 8'h20, 1'b0, 8'h30, 1'b0);

`ifdef SERIAL_SUB_EN
    runOp("sub 50-20", 8'h50, 8'h20, 1'b1, 8'h30, 1'b1);
    runOp("sub 20-50", 8'h20, 8'h50, 1'b1, 8'hD0, 1'b0);
    runOp("sub0 35+4A", 8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0);
`endif

    repeat (2) @(negedge clk);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
